// File: rtl/ddr3_mem_arbiter.sv
// Two-port round-robin arbiter in front of the DDR3 native port. Each request
// is tagged with its port index in bit 15; responses are routed back by that bit.
module ddr3_mem_arbiter #(
    parameter int unsigned BURST_LEN       = 4,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic          clock,
    input  logic          reset,

    input  logic [15:0]   p0_wr_i,
    input  logic          p0_rd_i,
    input  logic [31:0]   p0_addr_i,
    input  logic [127:0]  p0_write_data_i,
    input  logic [14:0]   p0_req_id_i,
    output logic          p0_accept_o,
    output logic          p0_ack_o,
    output logic          p0_error_o,
    output logic [127:0]  p0_read_data_o,
    output logic [14:0]   p0_resp_id_o,

    input  logic [15:0]   p1_wr_i,
    input  logic          p1_rd_i,
    input  logic [31:0]   p1_addr_i,
    input  logic [127:0]  p1_write_data_i,
    input  logic [14:0]   p1_req_id_i,
    output logic          p1_accept_o,
    output logic          p1_ack_o,
    output logic          p1_error_o,
    output logic [127:0]  p1_read_data_o,
    output logic [14:0]   p1_resp_id_o,

    output logic [15:0]   mem_wr_o,
    output logic          mem_rd_o,
    output logic [31:0]   mem_addr_o,
    output logic [127:0]  mem_write_data_o,
    output logic [15:0]   mem_req_id_o,
    input  logic          mem_accept_i,
    input  logic          mem_ack_i,
    input  logic          mem_error_i,
    input  logic [127:0]  mem_read_data_i,
    input  logic [15:0]   mem_resp_id_i
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_P0,
        OWN_P1
    } owner_t;

    localparam logic [3:0] BURST_LAST = 4'(BURST_LEN - 1);
    localparam logic [3:0] OUT_CAP    = 4'(MAX_OUTSTANDING);

    owner_t     owner;
    logic       last_served;
    logic [3:0] bcnt;
    logic [3:0] out0;
    logic [3:0] out1;

    logic req0, req1;
    logic elig0, elig1;

    assign req0  = (|p0_wr_i) | p0_rd_i;
    assign req1  = (|p1_wr_i) | p1_rd_i;
    assign elig0 = req0 & (out0 < OUT_CAP);
    assign elig1 = req1 & (out1 < OUT_CAP);

    assign p0_accept_o = mem_accept_i & (owner == OWN_P0) & elig0;
    assign p1_accept_o = mem_accept_i & (owner == OWN_P1) & elig1;

    always_comb begin
        mem_wr_o         = '0;
        mem_rd_o         = 1'b0;
        mem_addr_o       = '0;
        mem_write_data_o = '0;
        mem_req_id_o     = '0;
        if (owner == OWN_P0 && elig0) begin
            mem_wr_o         = p0_wr_i;
            mem_rd_o         = p0_rd_i;
            mem_addr_o       = p0_addr_i;
            mem_write_data_o = p0_write_data_i;
            mem_req_id_o     = {1'b0, p0_req_id_i};
        end else if (owner == OWN_P1 && elig1) begin
            mem_wr_o         = p1_wr_i;
            mem_rd_o         = p1_rd_i;
            mem_addr_o       = p1_addr_i;
            mem_write_data_o = p1_write_data_i;
            mem_req_id_o     = {1'b1, p1_req_id_i};
        end
    end

    // Responses are steered purely by the tag bit; data and tag are broadcast.
    assign p0_ack_o       = mem_ack_i   & ~mem_resp_id_i[15];
    assign p1_ack_o       = mem_ack_i   &  mem_resp_id_i[15];
    assign p0_error_o     = mem_error_i & ~mem_resp_id_i[15];
    assign p1_error_o     = mem_error_i &  mem_resp_id_i[15];
    assign p0_read_data_o = mem_read_data_i;
    assign p1_read_data_o = mem_read_data_i;
    assign p0_resp_id_o   = mem_resp_id_i[14:0];
    assign p1_resp_id_o   = mem_resp_id_i[14:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            owner       <= OWN_NONE;
            last_served <= 1'b1;
            bcnt        <= '0;
            out0        <= '0;
            out1        <= '0;
        end else begin
            case (owner)
                OWN_NONE: begin
                    bcnt <= '0;
                    if (elig0 && elig1)
                        owner <= last_served ? OWN_P0 : OWN_P1;
                    else if (elig0)
                        owner <= OWN_P0;
                    else if (elig1)
                        owner <= OWN_P1;
                end
                OWN_P0: begin
                    if (!elig0) begin
                        last_served <= 1'b0;
                        bcnt        <= '0;
                        owner       <= elig1 ? OWN_P1 : OWN_NONE;
                    end else if (p0_accept_o) begin
                        if (bcnt == BURST_LAST) begin
                            bcnt <= '0;
                            if (elig1) begin
                                owner       <= OWN_P1;
                                last_served <= 1'b0;
                            end
                        end else begin
                            bcnt <= bcnt + 4'd1;
                        end
                    end
                end
                OWN_P1: begin
                    if (!elig1) begin
                        last_served <= 1'b1;
                        bcnt        <= '0;
                        owner       <= elig0 ? OWN_P0 : OWN_NONE;
                    end else if (p1_accept_o) begin
                        if (bcnt == BURST_LAST) begin
                            bcnt <= '0;
                            if (elig0) begin
                                owner       <= OWN_P0;
                                last_served <= 1'b1;
                            end
                        end else begin
                            bcnt <= bcnt + 4'd1;
                        end
                    end
                end
                default: owner <= OWN_NONE;
            endcase

            // Accept and ack in the same cycle cancel; a stray ack saturates at 0.
            if (p0_accept_o && !p0_ack_o)
                out0 <= out0 + 4'd1;
            else if (!p0_accept_o && p0_ack_o && out0 != '0)
                out0 <= out0 - 4'd1;

            if (p1_accept_o && !p1_ack_o)
                out1 <= out1 + 4'd1;
            else if (!p1_accept_o && p1_ack_o && out1 != '0)
                out1 <= out1 - 4'd1;
        end
    end

endmodule

// File: tb/tb_ddr3_mem_arbiter.sv
// Bench for ddr3_mem_arbiter: a per-port grant/burst/outstanding model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_ddr3_mem_arbiter;

    localparam int BL = 4;
    localparam int MO = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic [15:0]  p0_wr_i, p1_wr_i;
    logic         p0_rd_i, p1_rd_i;
    logic [31:0]  p0_addr_i, p1_addr_i;
    logic [127:0] p0_write_data_i, p1_write_data_i;
    logic [14:0]  p0_req_id_i, p1_req_id_i;
    logic         p0_accept_o, p1_accept_o, p0_ack_o, p1_ack_o, p0_error_o, p1_error_o;
    logic [127:0] p0_read_data_o, p1_read_data_o;
    logic [14:0]  p0_resp_id_o, p1_resp_id_o;
    logic [15:0]  mem_wr_o;
    logic         mem_rd_o;
    logic [31:0]  mem_addr_o;
    logic [127:0] mem_write_data_o;
    logic [15:0]  mem_req_id_o;
    logic         mem_accept_i, mem_ack_i, mem_error_i;
    logic [127:0] mem_read_data_i;
    logic [15:0]  mem_resp_id_i;

    always #5 clock = ~clock;

    ddr3_mem_arbiter #(.BURST_LEN(BL), .MAX_OUTSTANDING(MO)) dut (
        .clock(clock), .reset(reset),
        .p0_wr_i(p0_wr_i), .p0_rd_i(p0_rd_i), .p0_addr_i(p0_addr_i),
        .p0_write_data_i(p0_write_data_i), .p0_req_id_i(p0_req_id_i),
        .p0_accept_o(p0_accept_o), .p0_ack_o(p0_ack_o), .p0_error_o(p0_error_o),
        .p0_read_data_o(p0_read_data_o), .p0_resp_id_o(p0_resp_id_o),
        .p1_wr_i(p1_wr_i), .p1_rd_i(p1_rd_i), .p1_addr_i(p1_addr_i),
        .p1_write_data_i(p1_write_data_i), .p1_req_id_i(p1_req_id_i),
        .p1_accept_o(p1_accept_o), .p1_ack_o(p1_ack_o), .p1_error_o(p1_error_o),
        .p1_read_data_o(p1_read_data_o), .p1_resp_id_o(p1_resp_id_o),
        .mem_wr_o(mem_wr_o), .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o),
        .mem_write_data_o(mem_write_data_o), .mem_req_id_o(mem_req_id_o),
        .mem_accept_i(mem_accept_i), .mem_ack_i(mem_ack_i), .mem_error_i(mem_error_i),
        .mem_read_data_i(mem_read_data_i), .mem_resp_id_i(mem_resp_id_i)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: m_own is -1 (nobody), 0 or 1; m_run counts accepts in the current tenure.
    int m_own = -1;
    int m_last = 1;
    int m_run = 0;
    int m_out[2];
    bit started = 0;

    function automatic bit m_req(input int p);
        return (p == 0) ? ((|p0_wr_i) || p0_rd_i) : ((|p1_wr_i) || p1_rd_i);
    endfunction

    function automatic bit m_elig(input int p);
        return m_req(p) && (m_out[p] < MO);
    endfunction

    function automatic bit m_acc(input int p);
        return mem_accept_i && (m_own == p) && m_elig(p);
    endfunction

    function automatic bit m_ack(input int p);
        return mem_ack_i && (int'(mem_resp_id_i[15]) == p);
    endfunction

    always @(posedge clock) begin
        bit e[2];
        bit a[2];
        bit k[2];
        if (reset) begin
            started = 1;
            m_own = -1; m_last = 1; m_run = 0;
            m_out[0] = 0; m_out[1] = 0;
        end else if (started) begin
            for (int p = 0; p < 2; p++) begin
                e[p] = m_elig(p);
                a[p] = m_acc(p);
                k[p] = m_ack(p);
            end
            if (m_own < 0) begin
                m_run = 0;
                if (e[0] && e[1]) m_own = 1 - m_last;
                else if (e[0])    m_own = 0;
                else if (e[1])    m_own = 1;
            end else if (!e[m_own]) begin
                m_last = m_own;
                m_run = 0;
                m_own = e[1 - m_own] ? 1 - m_own : -1;
            end else if (a[m_own]) begin
                m_run++;
                if (m_run == BL) begin
                    m_run = 0;
                    if (e[1 - m_own]) begin
                        m_last = m_own;
                        m_own = 1 - m_own;
                    end
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (a[p] && !k[p]) m_out[p]++;
                else if (k[p] && !a[p] && m_out[p] > 0) m_out[p]--;
            end
        end
    end

    always @(negedge clock) begin
        if (started) begin
            if (m_own >= 0 && m_elig(m_own)) begin
                chk("m_wr",   mem_wr_o, m_own == 0 ? p0_wr_i : p1_wr_i);
                chk("m_rd",   mem_rd_o, m_own == 0 ? p0_rd_i : p1_rd_i);
                chk("m_addr", mem_addr_o, m_own == 0 ? p0_addr_i : p1_addr_i);
                chk("m_wdat", mem_write_data_o, m_own == 0 ? p0_write_data_i : p1_write_data_i);
                chk("m_id",   mem_req_id_o, m_own == 0 ? {1'b0, p0_req_id_i} : {1'b1, p1_req_id_i});
            end else begin
                chk("m_wr_idle", mem_wr_o, 16'h0);
                chk("m_rd_idle", mem_rd_o, 1'b0);
            end
            chk("m_acc0", p0_accept_o, m_acc(0));
            chk("m_acc1", p1_accept_o, m_acc(1));
            chk("m_ack0", p0_ack_o, m_ack(0));
            chk("m_ack1", p1_ack_o, m_ack(1));
            chk("m_err0", p0_error_o, mem_error_i && !mem_resp_id_i[15]);
            chk("m_err1", p1_error_o, mem_error_i && mem_resp_id_i[15]);
            if (p0_ack_o) begin
                chk("m_rdat0", p0_read_data_o, mem_read_data_i);
                chk("m_rid0",  p0_resp_id_o, mem_resp_id_i[14:0]);
            end
            if (p1_ack_o) begin
                chk("m_rdat1", p1_read_data_o, mem_read_data_i);
                chk("m_rid1",  p1_resp_id_o, mem_resp_id_i[14:0]);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        p0_wr_i = '0; p0_rd_i = 1'b0; p0_addr_i = '0; p0_write_data_i = '0; p0_req_id_i = '0;
        p1_wr_i = '0; p1_rd_i = 1'b0; p1_addr_i = '0; p1_write_data_i = '0; p1_req_id_i = '0;
        mem_accept_i = 1'b0; mem_ack_i = 1'b0; mem_error_i = 1'b0;
        mem_read_data_i = '0; mem_resp_id_i = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        step();
        step();
        reset = 1'b0;
    endtask

    int n;
    int got;
    int exp_tie[13] = '{2, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

    initial begin
        reset = 1'b1;
        idle();
        do_reset();

        // single read, then a tagged write with error response on port 1
        p0_rd_i = 1'b1; p0_addr_i = 32'h100; p0_req_id_i = 15'h12; mem_accept_i = 1'b1;
        #1;
        chk("rst_acc0", p0_accept_o, 1'b0);
        chk("rst_rd",   mem_rd_o, 1'b0);
        step();
        chk("rd_valid", mem_rd_o, 1'b1);
        chk("rd_id",    mem_req_id_o, 16'h0012);
        chk("rd_addr",  mem_addr_o, 32'h100);
        chk("rd_acc0",  p0_accept_o, 1'b1);
        step();
        p0_rd_i = 1'b0; mem_accept_i = 1'b0;
        mem_ack_i = 1'b1; mem_resp_id_i = 16'h0012; mem_read_data_i = 128'hcafe_0000_1234;
        #1;
        chk("ack0",    p0_ack_o, 1'b1);
        chk("ack1_no", p1_ack_o, 1'b0);
        chk("rdat0",   p0_read_data_o, 128'hcafe_0000_1234);
        chk("rid0",    p0_resp_id_o, 15'h12);
        step();
        mem_ack_i = 1'b0;
        p1_wr_i = 16'h00ff; p1_addr_i = 32'h2000; p1_write_data_i = 128'h55aa; p1_req_id_i = 15'h7abc;
        step();
        chk("wr_strb", mem_wr_o, 16'h00ff);
        chk("wr_id",   mem_req_id_o, 16'hfabc);
        chk("wr_rd",   mem_rd_o, 1'b0);
        mem_accept_i = 1'b1;
        step();
        p1_wr_i = '0; mem_accept_i = 1'b0;
        mem_ack_i = 1'b1; mem_error_i = 1'b1; mem_resp_id_i = 16'hfabc;
        #1;
        chk("err1",    p1_error_o, 1'b1);
        chk("err0_no", p0_error_o, 1'b0);
        chk("ack1",    p1_ack_o, 1'b1);
        step();
        idle();

        // tie after reset: 4x p0, 4x p1, 4x p0
        do_reset();
        p0_rd_i = 1'b1; p0_req_id_i = 15'h11; p0_addr_i = 32'h10;
        p1_rd_i = 1'b1; p1_req_id_i = 15'h22; p1_addr_i = 32'h20;
        mem_accept_i = 1'b1;
        for (int i = 0; i < 13; i++) begin
            #1;
            got = p0_accept_o ? 0 : (p1_accept_o ? 1 : 2);
            chk($sformatf("tie_%0d", i), got, exp_tie[i]);
            step();
        end
        idle();

        // lone requester on p1 with acks keeping it below the cap
        do_reset();
        p1_rd_i = 1'b1; p1_req_id_i = 15'h33; mem_accept_i = 1'b1;
        mem_ack_i = 1'b1; mem_resp_id_i = 16'h8033;
        step();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (p1_accept_o) n++;
            step();
        end
        chk("lone_count", n, 10);
        idle();

        // outstanding cap on p0, handover to p1, one ack releases one more accept
        do_reset();
        p0_rd_i = 1'b1; p0_req_id_i = 15'h5; mem_accept_i = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (p0_accept_o) n++;
            step();
        end
        chk("cap_count", n, 8);
        p1_rd_i = 1'b1;
        #1;
        chk("cap_p1_wait", p1_accept_o, 1'b0);
        step();
        chk("cap_p1_acc", p1_accept_o, 1'b1);
        step();
        p1_rd_i = 1'b0;
        mem_ack_i = 1'b1; mem_resp_id_i = 16'h0005;
        n = 0;
        for (int i = 0; i < 7; i++) begin
            #1;
            if (p0_accept_o) n++;
            step();
            mem_ack_i = 1'b0;
        end
        chk("cap_release", n, 1);
        idle();

        // backpressure holds the p0 request stable
        do_reset();
        p0_rd_i = 1'b1; p0_addr_i = 32'h4000; p0_req_id_i = 15'h44;
        p1_rd_i = 1'b1; p1_addr_i = 32'h5000; p1_req_id_i = 15'h55;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_addr", mem_addr_o, 32'h4000);
            chk("bp_id",   mem_req_id_o, 16'h0044);
            chk("bp_acc1", p1_accept_o, 1'b0);
            step();
        end
        mem_accept_i = 1'b1;
        #1;
        chk("bp_acc0", p0_accept_o, 1'b1);
        step();
        idle();
        step();

        // reset on the 2nd accept of a p1 burst
        do_reset();
        p1_rd_i = 1'b1; p1_req_id_i = 15'h66; mem_accept_i = 1'b1;
        step();
        step();
        chk("mid_acc2", p1_accept_o, 1'b1);
        reset = 1'b1;
        p0_rd_i = 1'b1; p0_req_id_i = 15'h77;
        step();
        reset = 1'b0;
        #1;
        chk("mid_rd",   mem_rd_o, 1'b0);
        chk("mid_wr",   mem_wr_o, 16'h0);
        chk("mid_acc1", p1_accept_o, 1'b0);
        step();
        chk("mid_tie_id",  mem_req_id_o, 16'h0077);
        chk("mid_tie_acc", p0_accept_o, 1'b1);
        step();
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
